// File: rtl/mmu_mapper_gen.sv
// mmu_mapper_gen: per-task page mapper with write protect, register window and task-switch fuse.
// Map entries are stored in their 16-bit register layout: bit 15 wp, low FRAME_W bits the frame.
module mmu_mapper_gen #(
    parameter int LADR_W = 16,
    parameter int PADR_W = 24,
    parameter int PAGE_W = 5,
    parameter int TASK_W = 2,
    parameter logic [LADR_W-1:0] REG_BASE = 16'hF800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_i,
    input  logic              dma,
    input  logic              rw_n,
    input  logic [LADR_W-1:0] adr,
    input  logic [7:0]        dbi,
    output logic [7:0]        dbo,
    output logic [PADR_W-1:0] padr_o,
    output logic              wp_o,
    output logic              reg_sel_o
);
    localparam int OFF_W = LADR_W - PAGE_W;
    localparam int FRAME_W = PADR_W - OFF_W;
    localparam int NENT = 1 << (TASK_W + PAGE_W);
    localparam logic [15:0] ENT_MASK = 16'h8000 | 16'((1 << FRAME_W) - 1);

    logic [15:0] map [NENT];
    logic en, fault;
    logic [TASK_W-1:0] act, edit, pend;
    logic [7:0] fuse;

    logic hit, wr, ctl, fuse_wr, act_wr, dec, expire, wp_hit;
    logic [PAGE_W:0] k;
    logic [TASK_W+PAGE_W-1:0] eidx, tidx;
    logic [15:0] eent;
    logic [FRAME_W-1:0] tframe;
    logic twp;
    logic [7:0] creg, rbyte;

    always_comb begin
        hit = cyc_i & ~dma & (adr[LADR_W-1:PAGE_W+2] == REG_BASE[LADR_W-1:PAGE_W+2]);
        wr = hit & ~rw_n;
        ctl = adr[PAGE_W+1];
        k = adr[PAGE_W:0];
        eidx = {edit, adr[PAGE_W:1]};
        tidx = {act, adr[LADR_W-1:OFF_W]};
        eent = map[eidx];
        tframe = map[tidx][FRAME_W-1:0];
        twp = map[tidx][15];
        creg = k == 0 ? {7'b0, en} :
               k == 1 ? 8'(act) :
               k == 2 ? 8'(edit) :
               k == 3 ? 8'(pend) :
               k == 4 ? fuse :
               k == 5 ? {6'b0, fault, fuse != 8'd0} : 8'h00;
        rbyte = ctl ? creg : (adr[0] ? eent[15:8] : eent[7:0]);
        fuse_wr = wr & ctl & (k == 4);
        act_wr = wr & ctl & (k == 1);
        // Register writes to FUSE neither count nor expire; the write itself sets the new count.
        dec = cyc_i & ~dma & ~fuse_wr & (fuse != 8'd0);
        expire = dec & (fuse == 8'd1);
        wp_hit = en & cyc_i & ~dma & ~hit & ~rw_n & twp;
    end

    always_ff @(posedge clk)
        if (!rst && wr && !ctl)
            map[eidx] <= (adr[0] ? {dbi, eent[7:0]} : {eent[15:8], dbi}) & ENT_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbo <= '0;
            padr_o <= '0;
            wp_o <= 1'b0;
            reg_sel_o <= 1'b0;
            en <= 1'b0;
            act <= '0;
            edit <= '0;
            pend <= '0;
            fuse <= '0;
            fault <= 1'b0;
        end else begin
            reg_sel_o <= hit;
            if (hit && rw_n)
                dbo <= rbyte;
            padr_o <= (en & ~dma & ~hit) ? {tframe, adr[OFF_W-1:0]} : PADR_W'(adr);
            wp_o <= wp_hit;
            if (wr && ctl && k == 0)
                en <= dbi[0];
            // A CPU write to ACT overrides the fuse's task switch on the same edge.
            if (act_wr)
                act <= dbi[TASK_W-1:0];
            else if (expire)
                act <= pend;
            if (wr && ctl && k == 2)
                edit <= dbi[TASK_W-1:0];
            if (wr && ctl && k == 3)
                pend <= dbi[TASK_W-1:0];
            if (fuse_wr)
                fuse <= dbi;
            else if (dec)
                fuse <= fuse - 8'd1;
            if (wp_hit)
                fault <= 1'b1;
            else if (wr && ctl && k == 5 && dbi[1])
                fault <= 1'b0;
        end
    end
endmodule
